led_status_gen: RTL



---
 rtl/led_status_if.sv | 39 +++
 rtl/led_status_gen.sv | 136 +++++++++++++
 2 files changed

// File: rtl/led_status_if.sv
// Bundle of the LED status generator's datapath-side inputs and LED-controller-side outputs.
interface led_status_if;
    logic        tx_pma_ready_async;
    logic        rx_pma_ready_async;
    logic        sel_display_async;
    logic        tx_data_valid;
    logic        rx_data_valid;
    logic        rx_word_err;
    logic        start;
    logic        abort;
    logic [7:0]  status;
    logic [15:0] err_count;

    modport master (
        output tx_pma_ready_async,
        output rx_pma_ready_async,
        output sel_display_async,
        output tx_data_valid,
        output rx_data_valid,
        output rx_word_err,
        output start,
        output abort,
        input  status,
        input  err_count
    );

    modport slave (
        input  tx_pma_ready_async,
        input  rx_pma_ready_async,
        input  sel_display_async,
        input  tx_data_valid,
        input  rx_data_valid,
        input  rx_word_err,
        input  start,
        input  abort,
        output status,
        output err_count
    );
endinterface

// File: rtl/led_status_gen.sv
// LED status vector: async input synchronisers, traffic activity stretchers and the
// link-monitor measurement FSM (mon_active / mon_error / mon_done, saturating err_count).
module led_status_gen #(
    parameter logic [31:0] WINDOW  = 32'd5000000,
    parameter logic [23:0] STRETCH = 24'd5000000
) (
    input  logic        clk,
    input  logic        reset,
    led_status_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StLockWait, StRun, StDone} state_e;

    // Two-flop synchronisers, bit order {sel_display, tx_ready, rx_ready}.
    logic [2:0] meta_q;
    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {bus.sel_display_async, bus.tx_pma_ready_async, bus.rx_pma_ready_async};
            sync_q <= meta_q;
        end
    end

    logic both_ready;
    assign both_ready = sync_q[1] & sync_q[0];

    // Activity stretchers. The flag registers the next counter value so a strobe in
    // cycle N shows from N+1 and the last strobe holds it through N+STRETCH.
    logic [23:0] tx_cnt_q, tx_cnt_d;
    logic [23:0] rx_cnt_q, rx_cnt_d;
    logic        tx_act_q, rx_act_q;

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (bus.tx_data_valid) begin
            tx_cnt_d = STRETCH;
        end else if (tx_cnt_q != '0) begin
            tx_cnt_d = tx_cnt_q - 24'd1;
        end

        rx_cnt_d = rx_cnt_q;
        if (bus.rx_data_valid) begin
            rx_cnt_d = STRETCH;
        end else if (rx_cnt_q != '0) begin
            rx_cnt_d = rx_cnt_q - 24'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            tx_act_q <= 1'b0;
            rx_act_q <= 1'b0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            tx_act_q <= (tx_cnt_d != '0);
            rx_act_q <= (rx_cnt_d != '0);
        end
    end

    // Measurement FSM with registered outputs.
    state_e      state_q;
    logic [31:0] win_cnt_q;
    logic [15:0] err_cnt_q;
    logic        mon_active_q, mon_error_q, mon_done_q;
    logic        err_hit;

    assign err_hit = bus.rx_data_valid & bus.rx_word_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            win_cnt_q    <= '0;
            err_cnt_q    <= '0;
            mon_active_q <= 1'b0;
            mon_error_q  <= 1'b0;
            mon_done_q   <= 1'b0;
        end else if (bus.abort) begin
            state_q      <= StIdle;
            mon_active_q <= 1'b0;
            mon_error_q  <= 1'b0;
            mon_done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        err_cnt_q    <= '0;
                        win_cnt_q    <= '0;
                        mon_error_q  <= 1'b0;
                        mon_done_q   <= 1'b0;
                        mon_active_q <= 1'b1;
                        state_q      <= both_ready ? StRun : StLockWait;
                    end
                end
                StLockWait: begin
                    if (both_ready) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    // Errors on the final cycle still count and land with the DONE edge.
                    if (err_hit) begin
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_q <= err_cnt_q + 16'd1;
                        end
                        mon_error_q <= 1'b1;
                    end
                    if (!both_ready) begin
                        mon_error_q  <= 1'b1;
                        mon_active_q <= 1'b0;
                        mon_done_q   <= 1'b1;
                        state_q      <= StDone;
                    end else if (win_cnt_q == WINDOW - 32'd1) begin
                        mon_active_q <= 1'b0;
                        mon_done_q   <= 1'b1;
                        state_q      <= StDone;
                    end else begin
                        win_cnt_q <= win_cnt_q + 32'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.status = {sync_q[2], tx_act_q, rx_act_q, mon_active_q, mon_error_q, mon_done_q,
                         sync_q[1], sync_q[0]};
    assign bus.err_count = err_cnt_q;

endmodule
